// File: rtl/approx_umul_pipe.sv
// Pipelined unsigned approximate multiplier with a per-beat exact/approx select and valid/ready streaming.
// Optional error statistics (shadow exact product, err_sum/err_cnt) are built when ERR_STAT_EN is defined.
module approx_umul_pipe #(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 6,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          x,
  input  logic [WIDTH-1:0]          y,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*WIDTH-1:0]        z,
  output logic                      out_mode,
  input  logic                      stat_clr,
  output logic [2*WIDTH+CNT_W-1:0]  err_sum,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int PW  = 2 * WIDTH;
  localparam int SW  = PW + CNT_W;
  localparam int SW1 = SW + 1;
  localparam int L   = STAGES - 1;
  localparam logic [PW-1:0] APPROX_MASK = {PW{1'b1}} << TRUNC;

  // Handshake: a stage advances when it holds a beat and its successor can take it.
  // nxt_ok[k] means stage k can accept a beat this cycle; nxt_ok[STAGES] is the consumer.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] adv, load;
  logic [STAGES:0]   nxt_ok;

  always_comb begin
    adv            = '0;
    nxt_ok         = '0;
    nxt_ok[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]    = valid_q[k] && nxt_ok[k+1];
      nxt_ok[k] = !valid_q[k] || adv[k];
    end
  end

  assign in_ready = nxt_ok[0];

  always_comb begin
    load    = '0;
    load[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = load[k] || (valid_q[k] && !adv[k]);
    end
  end

  // Carry-save reduction of the (optionally column-masked) partial-product rows.
  logic [PW-1:0] cs_s, cs_c, row, t_s, pp_mask;

  always_comb begin
    cs_s    = '0;
    cs_c    = '0;
    row     = '0;
    t_s     = '0;
    pp_mask = mode ? {PW{1'b1}} : APPROX_MASK;
    for (int j = 0; j < WIDTH; j++) begin
      row  = y[j] ? (PW'(x) << j) : '0;
      row  = row & pp_mask;
      t_s  = cs_s ^ cs_c ^ row;
      cs_c = ((cs_s & cs_c) | (cs_s & row) | (cs_c & row)) << 1;
      cs_s = t_s;
    end
  end

  // Stage data. The last stage stores the resolved product in sum_q; earlier stages keep sum/carry.
  logic [PW-1:0]     sum_q [STAGES];
  logic [PW-1:0]     sum_d [STAGES];
  logic [PW-1:0]     car_q [STAGES];
  logic [PW-1:0]     car_d [STAGES];
  logic [STAGES-1:0] mode_q, mode_d;
  logic [PW-1:0]     src_s [STAGES];
  logic [PW-1:0]     src_c [STAGES];
  logic [STAGES-1:0] src_m;

  always_comb begin
    src_s[0] = cs_s;
    src_c[0] = cs_c;
    src_m    = '0;
    src_m[0] = mode;
    for (int k = 1; k < STAGES; k++) begin
      src_s[k] = sum_q[k-1];
      src_c[k] = car_q[k-1];
      src_m[k] = mode_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]  = sum_q[k];
      car_d[k]  = car_q[k];
      mode_d[k] = mode_q[k];
      if (load[k]) begin
        mode_d[k] = src_m[k];
        if (k == L) begin
          sum_d[k] = src_s[k] + src_c[k];
          car_d[k] = '0;
        end else begin
          sum_d[k] = src_s[k];
          car_d[k] = src_c[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      mode_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        car_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        car_q[k] <= car_d[k];
      end
    end
  end

  assign out_valid = valid_q[L];
  assign z         = sum_q[L];
  assign out_mode  = mode_q[L];

`ifdef ERR_STAT_EN
  // Shadow exact product travels with each beat so the error is known at the output transfer.
  logic [PW-1:0]    ex_q [STAGES];
  logic [PW-1:0]    ex_d [STAGES];
  logic [SW-1:0]    err_sum_q, err_sum_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [PW-1:0]    diff;
  logic [SW1-1:0]   sum_ext;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ex_d[k] = ex_q[k];
      if (load[k]) begin
        ex_d[k] = (k == 0) ? PW'(x) * PW'(y) : ex_q[(k == 0) ? 0 : k-1];
      end
    end
  end

  always_comb begin
    diff      = ex_q[L] - sum_q[L];
    sum_ext   = {1'b0, err_sum_q} + SW1'(diff);
    err_sum_d = err_sum_q;
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && !out_mode) begin
      err_sum_d = sum_ext[SW] ? {SW{1'b1}} : sum_ext[SW-1:0];
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    end
    if (stat_clr) begin
      err_sum_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum_q <= '0;
      err_cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ex_q[k] <= '0;
      end
    end else begin
      err_sum_q <= err_sum_d;
      err_cnt_q <= err_cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        ex_q[k] <= ex_d[k];
      end
    end
  end

  assign err_sum = err_sum_q;
  assign err_cnt = err_cnt_q;
`else
  assign err_sum = '0;
  assign err_cnt = '0;
`endif

endmodule
